uart_frame_receiver: RTL and testbench
======================================

// Module: uart_frame_receiver
// PURPOSE
// - Avalon-MM master that polls the RS232 UART core and assembles glove-data frames.
// - Publishes each validated payload to the display stage (VGA_display data input).
// - Frame format: SYNC byte, FRAME_BYTES payload bytes, then a checksum byte.
// - Checksum = XOR of the payload bytes.
// - Sits between the UART IP and the display path; it only reads, never writes the UART.
// PARAMETERS
// FRAME_BYTES  4      payload bytes per frame (1..16)
// SYNC_BYTE    8'hA5  frame start marker
// TIMEOUT_CYC  50000  max idle cycles between bytes inside a frame before abort
// RX_BASE      0      UART RX data register byte address
// STATUS_BASE  8      UART status register byte address; bit 7 = RX_OK
// PORTS
// avm_clk          in   1                 system clock
// avm_rst          in   1                 async reset, active-high
// avm_address      out  5                 Avalon address
// avm_read         out  1                 Avalon read strobe
// avm_readdata     in   32                Avalon read data; bits [7:0] used
// avm_write        out  1                 tied 0
// avm_writedata    out  32                tied 0
// avm_waitrequest  in   1                 Avalon stall
// o_frame          out  8*FRAME_BYTES     last good payload; first received byte in MSBs
// o_frame_valid    out  1                 1-cycle pulse when o_frame updates
// o_frame_err      out  1                 1-cycle pulse on checksum mismatch
// o_timeout        out  1                 1-cycle pulse on inter-byte timeout abort
// BEHAVIOUR
// - Reset (async, avm_rst=1) forces:
//   - avm_read=0, avm_address=STATUS_BASE.
//   - o_frame=0; o_frame_valid, o_frame_err, o_timeout = 0.
//   - Bus FSM to S_POLL_STATUS, frame phase to HUNT, byte and timeout counters to 0.
// - Bus FSM:
//   - S_POLL_STATUS: avm_read=1, address=STATUS_BASE.
//   - S_READ_RX: avm_read=1, address=RX_BASE.
//   - Read and address stay constant while avm_waitrequest=1.
//   - A transfer completes on the first cycle with avm_read=1 and avm_waitrequest=0; readdata is sampled in that cycle.
//   - Status completes with bit7=1: go to S_READ_RX.
//   - Status completes with bit7=0: reissue the status read.
//   - RX read completes: pass byte readdata[7:0] to the frame phase, return to S_POLL_STATUS.
//   - avm_read deasserts for exactly 1 cycle between consecutive transfers.
// - Frame phase (advances only on an accepted byte):
//   - HUNT: byte==SYNC_BYTE -> PAYLOAD, clear index and running XOR; any other byte is dropped.
//   - PAYLOAD: shift the byte into the staging register and XOR it into the running sum. After FRAME_BYTES bytes -> CHECK. SYNC_BYTE inside the payload is ordinary data; there is no resync.
//   - CHECK: byte==XOR -> o_frame<=staging, o_frame_valid=1 the cycle after the completing read. Byte!=XOR -> o_frame_err=1, o_frame unchanged. Either way -> HUNT.
// - Timeout:
//   - Counter runs while the phase is PAYLOAD or CHECK and clears on every accepted byte. It saturates at TIMEOUT_CYC.
//   - Abort is evaluated only when a status read completes with RX_OK=0 and counter>=TIMEOUT_CYC.
//   - On abort: o_timeout pulses, phase -> HUNT, staging is discarded, o_frame is unchanged.
//   - An in-flight transfer is never cut short.
// - At most one of valid/err/timeout pulses in any cycle.
// - Reset mid-transfer drops avm_read immediately; any partial frame is lost.
// TESTING
// - Good frame, no stalls:
//   - UART bytes A5 01 02 03 04 04 -> o_frame=32'h01020304.
//   - o_frame_valid pulses once, 1 cycle after the 6th RX read completes.
// - Leading garbage: 00 FF 3C A5 01 02 03 04 04 -> garbage ignored, same single valid pulse and value.
// - Bad checksum after the good frame: A5 11 22 33 44 05 -> o_frame_err pulses once, o_frame stays 32'h01020304.
// - avm_waitrequest held 3 cycles on every read:
//   - address and read remain stable during each stall.
//   - result is identical to the good-frame test.
// - Stall and recovery, with TIMEOUT_CYC=100:
//   - A5 01 then RX_OK=0 for 150 cycles -> o_timeout pulses once.
//   - A following full good frame is accepted.
// - Reset pulse after A5 01 02:
//   - all outputs 0 and avm_read=0 while reset is held.
//   - After release, the bytes 03 04 04 produce no pulse.
//   - A fresh good frame then produces valid.

Source files
------------

// File: rtl/uart_frame_receiver.sv
// Avalon-MM master that polls an RS232 UART core, assembles SYNC/payload/XOR-checksum
// frames and publishes each validated payload to the display stage.
module uart_frame_receiver #(
  parameter int         FRAME_BYTES = 4,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         TIMEOUT_CYC = 50000,
  parameter logic [4:0] RX_BASE     = 5'd0,
  parameter logic [4:0] STATUS_BASE = 5'd8
) (
  input  logic                     avm_clk,
  input  logic                     avm_rst,
  output logic [4:0]               avm_address,
  output logic                     avm_read,
  input  logic [31:0]              avm_readdata,
  output logic                     avm_write,
  output logic [31:0]              avm_writedata,
  input  logic                     avm_waitrequest,
  output logic [8*FRAME_BYTES-1:0] o_frame,
  output logic                     o_frame_valid,
  output logic                     o_frame_err,
  output logic                     o_timeout
);

  localparam int SW = 8 * FRAME_BYTES;
  localparam int IW = $clog2(FRAME_BYTES + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [0:0] {S_POLL_STATUS, S_READ_RX} bus_state_t;
  typedef enum logic [1:0] {PH_HUNT, PH_PAYLOAD, PH_CHECK} phase_t;

  bus_state_t r_state, w_state_next;
  logic       r_read, w_read_next;

  phase_t     r_phase, w_phase_next;

  logic [IW-1:0] r_idx;
  logic [7:0]    r_xor;
  logic [SW-1:0] r_stage;
  logic [SW-1:0] r_frame;
  logic [TW-1:0] r_tmo_cnt;
  logic          r_frame_valid, r_frame_err, r_timeout;

  logic          w_done, w_byte_valid, w_status_empty;
  logic [7:0]    w_byte;
  logic [SW-1:0] w_byte_ext;
  logic          w_start, w_shift, w_check_byte, w_frame_ok, w_frame_bad, w_abort;
  logic          w_unused_readdata;

  assign avm_write         = 1'b0;
  assign avm_writedata     = 32'd0;
  assign w_unused_readdata = ^avm_readdata[31:8];

  // ---------------- Bus FSM ----------------
  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      r_state <= S_POLL_STATUS;
      r_read  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_read  <= w_read_next;
    end
  end

  // r_read low is the one-cycle gap that separates consecutive transfers.
  always_comb begin
    w_state_next = r_state;
    w_read_next  = r_read;
    if (!r_read) begin
      w_read_next = 1'b1;
    end else if (!avm_waitrequest) begin
      w_read_next = 1'b0;
      if (r_state == S_POLL_STATUS) begin
        if (avm_readdata[7]) w_state_next = S_READ_RX;
      end else begin
        w_state_next = S_POLL_STATUS;
      end
    end
  end

  always_comb begin
    avm_read       = r_read;
    avm_address    = (r_state == S_READ_RX) ? RX_BASE : STATUS_BASE;
    w_done         = r_read & ~avm_waitrequest;
    w_byte_valid   = w_done & (r_state == S_READ_RX);
    w_status_empty = w_done & (r_state == S_POLL_STATUS) & ~avm_readdata[7];
    w_byte         = avm_readdata[7:0];
  end

  // ---------------- Frame phase FSM ----------------
  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) r_phase <= PH_HUNT;
    else         r_phase <= w_phase_next;
  end

  always_comb begin
    w_phase_next = r_phase;
    case (r_phase)
      PH_HUNT: begin
        if (w_start) w_phase_next = PH_PAYLOAD;
      end
      PH_PAYLOAD: begin
        if (w_shift && r_idx == IW'(FRAME_BYTES - 1)) w_phase_next = PH_CHECK;
        else if (w_abort)                              w_phase_next = PH_HUNT;
      end
      PH_CHECK: begin
        if (w_check_byte || w_abort) w_phase_next = PH_HUNT;
      end
      default: w_phase_next = PH_HUNT;
    endcase
  end

  always_comb begin
    w_start      = w_byte_valid && (r_phase == PH_HUNT) && (w_byte == SYNC_BYTE);
    w_shift      = w_byte_valid && (r_phase == PH_PAYLOAD);
    w_check_byte = w_byte_valid && (r_phase == PH_CHECK);
    w_frame_ok   = w_check_byte && (w_byte == r_xor);
    w_frame_bad  = w_check_byte && (w_byte != r_xor);
    // Only an empty status poll can abort, so an in-flight RX read always lands.
    w_abort      = w_status_empty && (r_phase != PH_HUNT) && (r_tmo_cnt >= TW'(TIMEOUT_CYC));
    w_byte_ext   = SW'(w_byte);
  end

  // ---------------- Datapath and registered pulses ----------------
  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      r_idx         <= '0;
      r_xor         <= '0;
      r_stage       <= '0;
      r_frame       <= '0;
      r_tmo_cnt     <= '0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_frame_valid <= w_frame_ok;
      r_frame_err   <= w_frame_bad;
      r_timeout     <= w_abort;

      if (w_start) begin
        r_idx   <= '0;
        r_xor   <= '0;
        r_stage <= '0;
      end else if (w_shift) begin
        r_idx   <= r_idx + 1'b1;
        r_xor   <= r_xor ^ w_byte;
        r_stage <= (r_stage << 8) | w_byte_ext;
      end else if (w_abort) begin
        r_stage <= '0;
      end

      if (w_frame_ok) r_frame <= r_stage;

      if (w_byte_valid || w_abort || r_phase == PH_HUNT) r_tmo_cnt <= '0;
      else if (r_tmo_cnt < TW'(TIMEOUT_CYC))             r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  assign o_frame       = r_frame;
  assign o_frame_valid = r_frame_valid;
  assign o_frame_err   = r_frame_err;
  assign o_timeout     = r_timeout;

endmodule

// File: tb/tb_uart_frame_receiver.sv
// Self-checking bench for uart_frame_receiver: a behavioural UART slave on the Avalon bus
// plus a byte-level frame model that predicts every valid/err pulse and payload.
module tb_uart_frame_receiver;

  localparam int         FB     = 4;
  localparam int         TMO    = 100;
  localparam logic [7:0] SYNC   = 8'hA5;
  localparam logic [4:0] A_RX   = 5'd0;
  localparam logic [4:0] A_STAT = 5'd8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  avm_address;
  logic        avm_read;
  logic [31:0] readdata = '0;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic        waitreq = 1'b0;
  logic [31:0] o_frame;
  logic        o_frame_valid, o_frame_err, o_timeout;

  always #5 clk = ~clk;

  uart_frame_receiver #(
    .FRAME_BYTES(FB), .SYNC_BYTE(SYNC), .TIMEOUT_CYC(TMO),
    .RX_BASE(A_RX), .STATUS_BASE(A_STAT)
  ) dut (
    .avm_clk(clk), .avm_rst(rst),
    .avm_address(avm_address), .avm_read(avm_read), .avm_readdata(readdata),
    .avm_write(avm_write), .avm_writedata(avm_writedata), .avm_waitrequest(waitreq),
    .o_frame(o_frame), .o_frame_valid(o_frame_valid), .o_frame_err(o_frame_err),
    .o_timeout(o_timeout)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // UART slave state
  logic [7:0]  uart_q[$];
  int          empty_left = 0;
  int          stall_fixed = -1;
  bit          in_xfer = 0, done_flag = 0, done_rx = 0, done_ready = 0, gap_prev = 0;
  int          wait_left = 0;
  logic [4:0]  xfer_addr = '0;

  // Frame model state
  bit          m_in_frame = 0;
  logic [7:0]  m_pl[$];
  logic [31:0] m_frame = '0;
  bit          to_window = 0;
  int          to_seen = 0;

  task automatic model_byte(input logic [7:0] b, output bit ev_v, output bit ev_e);
    logic [7:0]  x;
    logic [31:0] f;
    ev_v = 0;
    ev_e = 0;
    x = '0;
    f = '0;
    if (!m_in_frame) begin
      if (b == SYNC) begin
        m_in_frame = 1;
        m_pl.delete();
      end
    end else if (m_pl.size() < FB) begin
      m_pl.push_back(b);
    end else begin
      foreach (m_pl[i]) begin
        x = x ^ m_pl[i];
        f = (f << 8) | {24'd0, m_pl[i]};
      end
      if (b == x) begin
        ev_v = 1;
        m_frame = f;
      end else begin
        ev_e = 1;
      end
      m_in_frame = 0;
    end
  endtask

  // Avalon slave and pulse monitor, evaluated on the falling edge.
  initial begin
    logic [31:0] r;
    logic [7:0]  b;
    bit          ev_v, ev_e;
    forever begin
      @(negedge clk);
      ev_v = 0;
      ev_e = 0;
      if (rst) begin
        in_xfer = 0; done_flag = 0; gap_prev = 0; waitreq = 1'b0;
      end else begin
        if (gap_prev) begin
          check_eq("read_reissue", avm_read, 1);
          gap_prev = 0;
        end
        if (done_flag) begin
          done_flag = 0;
          in_xfer = 0;
          check_eq("read_gap", avm_read, 0);
          gap_prev = 1;
          if (done_rx) begin
            if (uart_q.size() > 0) begin
              b = uart_q.pop_front();
              model_byte(b, ev_v, ev_e);
            end
            empty_left = $urandom_range(0, 3);
          end else if (!done_ready && empty_left > 0) begin
            empty_left--;
          end
        end
        if (avm_read) begin
          if (!in_xfer) begin
            in_xfer = 1;
            xfer_addr = avm_address;
            wait_left = (stall_fixed >= 0) ? stall_fixed : $urandom_range(0, 3);
          end else begin
            check_eq("addr_stable", avm_address, xfer_addr);
          end
          if (wait_left > 0) begin
            waitreq = 1'b1;
            wait_left--;
          end else begin
            waitreq = 1'b0;
            r = $urandom();
            if (xfer_addr == A_RX) begin
              done_rx = 1;
              check_eq("rx_has_data", uart_q.size() > 0, 1);
              r[7:0] = (uart_q.size() > 0) ? uart_q[0] : 8'h00;
            end else begin
              if (xfer_addr != A_STAT) check_eq("address_legal", xfer_addr, A_STAT);
              done_rx = 0;
              done_ready = (uart_q.size() > 0) && (empty_left == 0);
              r[7] = done_ready;
            end
            readdata = r;
            done_flag = 1;
          end
        end else begin
          if (in_xfer) check_eq("read_stable", avm_read, 1);
          waitreq = 1'($urandom_range(0, 1));
        end
      end
      if (o_frame_valid || ev_v) check_eq("valid_pulse", o_frame_valid, ev_v);
      if (ev_v)                  check_eq("frame_value", o_frame, m_frame);
      if (o_frame_err || ev_e)   check_eq("err_pulse", o_frame_err, ev_e);
      if (o_timeout) begin
        if (to_window) to_seen++;
        else           check_eq("spurious_timeout", o_timeout, 0);
      end
    end
  end

  task automatic drain();
    for (int k = 0; k < 3000 && uart_q.size() > 0; k++) @(negedge clk);
    check_eq("drain", uart_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic send_bytes(input logic [7:0] v[$]);
    foreach (v[i]) uart_q.push_back(v[i]);
    drain();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_read"},   avm_read, 0);
    check_eq({tag, "_addr"},   avm_address, A_STAT);
    check_eq({tag, "_frame"},  o_frame, 0);
    check_eq({tag, "_pulses"}, {o_frame_valid, o_frame_err, o_timeout}, 3'b000);
    check_eq({tag, "_write"},  {avm_write, avm_writedata}, 33'd0);
  endtask

  initial begin
    logic [7:0] v[$];
    logic [7:0] x, g;
    int         ng;

    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;

    v = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    send_bytes(v);
    check_eq("good_frame", o_frame, 32'h01020304);

    v = '{8'h00, 8'hFF, 8'h3C, 8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    send_bytes(v);
    check_eq("garbage_frame", o_frame, 32'h01020304);

    v = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h05};
    send_bytes(v);
    check_eq("bad_cksum_hold", o_frame, 32'h01020304);

    stall_fixed = 3;
    v = '{8'hA5, 8'h0A, 8'hB0, 8'hC0, 8'hDD, 8'hA7};
    send_bytes(v);
    check_eq("stall_frame", o_frame, 32'h0AB0C0DD);
    v = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    send_bytes(v);
    check_eq("stall_good_frame", o_frame, 32'h01020304);
    stall_fixed = -1;

    // Partial frame followed by a long empty stretch must abort exactly once.
    v = '{8'hA5, 8'h01};
    send_bytes(v);
    to_seen = 0;
    to_window = 1;
    repeat (150) @(negedge clk);
    to_window = 0;
    check_eq("timeout_count", to_seen, 1);
    check_eq("timeout_frame_hold", o_frame, 32'h01020304);
    m_in_frame = 0;
    v = '{8'hA5, 8'h10, 8'h20, 8'h30, 8'h40, 8'h40};
    send_bytes(v);
    check_eq("after_timeout_frame", o_frame, 32'h10203040);

    // Reset mid-frame drops the partial payload.
    v = '{8'hA5, 8'h01, 8'h02};
    send_bytes(v);
    #2 rst = 1'b1;
    m_in_frame = 0;
    m_frame = '0;
    repeat (3) begin
      @(negedge clk);
      check_reset_outputs("midrst");
    end
    rst = 1'b0;
    v = '{8'h03, 8'h04, 8'h04};
    send_bytes(v);
    check_eq("post_rst_no_frame", o_frame, 32'h0);
    v = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    send_bytes(v);
    check_eq("post_rst_frame", o_frame, 32'h01020304);

    // Randomized frames with garbage and occasional corrupted checksums.
    for (int f = 0; f < 20; f++) begin
      v.delete();
      ng = $urandom_range(0, 3);
      for (int i = 0; i < ng; i++) begin
        g = 8'($urandom_range(0, 255));
        if (g == SYNC) g = 8'h5A;
        v.push_back(g);
      end
      v.push_back(SYNC);
      x = '0;
      for (int i = 0; i < FB; i++) begin
        g = 8'($urandom_range(0, 255));
        x = x ^ g;
        v.push_back(g);
      end
      if ($urandom_range(0, 3) == 0) x = x ^ 8'($urandom_range(1, 255));
      v.push_back(x);
      send_bytes(v);
      check_eq("rand_frame", o_frame, m_frame);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
